ap_mult_err_sweep: RTL and testbench

- Sequential evaluation controller for one approximate unsigned Wallace multiplier instance built from ap_com_* compressor cells.
- Sweeps every (a, b) operand pair exhaustively and drives each pair into the external multiplier under test.
- Compares the returned approximate product with an internally computed exact product and accumulates error metrics.
- Sits in the evolutionary-search loop: software starts a sweep, waits for done, then reads the metrics as a fitness score.

---
 rtl/ap_mult_err_sweep_pkg.sv | 31 +++
 rtl/ap_mult_err_sweep_delay.sv | 46 ++++
 rtl/ap_mult_err_sweep.sv | 121 ++++++++++++
 tb/tb_ap_mult_err_sweep.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ap_mult_err_sweep_pkg.sv
// Shared types and width helpers for the approximate-multiplier error sweep.
// Widths are functions of the operand width so every WIDTH stays consistent.
package ap_sweep_pkg;

  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, FLUSH, DONE} sweep_state_t;

  localparam int MAX_DUT_LAT = 7;
  localparam int DEF_WIDTH   = 4;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sum_w(input int w);
    return 4 * w;
  endfunction

  function automatic int sq_w(input int w);
    return 6 * w;
  endfunction

  localparam int PROD_W = prod_w(DEF_WIDTH);
  localparam int CNT_W  = cnt_w(DEF_WIDTH);
  localparam int SUM_W  = sum_w(DEF_WIDTH);
  localparam int SQ_W   = sq_w(DEF_WIDTH);

endpackage

// File: rtl/ap_mult_err_sweep_delay.sv
// Valid+data delay line of DEPTH registers; a plain wire when DEPTH is 0.
// Keeps the exact product aligned with the multiplier's returned product.
module ap_sweep_delay #(
  parameter int DEPTH = 0,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, flush};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0] v_q;
      logic [DW-1:0]    d_q [DEPTH];

      // flush drops every in-flight valid so an aborted sweep accumulates nothing more
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
          v_q[0] <= in_valid & ~flush;
          d_q[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            v_q[i] <= v_q[i-1] & ~flush;
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign out_valid = v_q[DEPTH-1];
      assign out_data  = d_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ap_mult_err_sweep.sv
// Exhaustive operand sweep with error metrics for one approximate multiplier.
// Define AP_SWEEP_SQERR_EN to add the sum-of-squared-error output.
module ap_mult_err_sweep
  import ap_sweep_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DUT_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   ap_prod,
  output logic [2*WIDTH:0]     err_cnt,
  output logic [4*WIDTH-1:0]   sum_abs_err,
`ifdef AP_SWEEP_SQERR_EN
  output logic [6*WIDTH-1:0]   sum_sq_err,
`endif
  output logic [2*WIDTH-1:0]   max_abs_err
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam int SW = sum_w(WIDTH);
  localparam logic [2:0] DRAIN_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  sweep_state_t state_q, state_d;
  logic [PW-1:0] idx_q;
  logic [2:0]    drain_q;
  logic          sweep_entry, stop_now, acc_en;
  logic          d_valid;
  logic [PW-1:0] exact, exact_d, diff;

  assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign mult_a   = idx_q[PW-1:WIDTH];
  assign mult_b   = idx_q[WIDTH-1:0];
  assign stop_now = busy & abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (abort) state_d = IDLE;
               else if (idx_q == '1) state_d = (DUT_LAT > 0) ? DRAIN : FLUSH;
      DRAIN:   if (abort) state_d = IDLE;
               else if (drain_q == DRAIN_LAST) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (start) state_d = SWEEP;
      default: state_d = IDLE;
    endcase
  end

  assign sweep_entry = (state_d == SWEEP) && (state_q != SWEEP);

  // idx holds at the last pair through DRAIN so the multiplier inputs stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) ? drain_q + 3'd1 : 3'd0;
      if (sweep_entry) idx_q <= '0;
      else if (state_q == SWEEP && idx_q != '1) idx_q <= idx_q + 1'b1;
    end
  end

  assign exact = PW'(mult_a) * PW'(mult_b);

  ap_sweep_delay #(.DEPTH(DUT_LAT), .DW(PW)) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (stop_now),
    .in_valid  (state_q == SWEEP),
    .in_data   (exact),
    .out_valid (d_valid),
    .out_data  (exact_d)
  );

  assign diff   = (exact_d >= ap_prod) ? exact_d - ap_prod : ap_prod - exact_d;
  assign acc_en = d_valid & ~stop_now;

`ifdef AP_SWEEP_SQERR_EN
  localparam int QW = sq_w(WIDTH);
  logic [2*PW-1:0] diff_sq;
  assign diff_sq = (2*PW)'(diff) * (2*PW)'(diff);
`endif

  // Metrics clear on every sweep entry and otherwise only move on aligned valid pairs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
`ifdef AP_SWEEP_SQERR_EN
      sum_sq_err  <= '0;
`endif
    end else if (sweep_entry) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
`ifdef AP_SWEEP_SQERR_EN
      sum_sq_err  <= '0;
`endif
    end else if (acc_en) begin
      err_cnt     <= err_cnt + CW'(diff != '0);
      sum_abs_err <= sum_abs_err + SW'(diff);
      if (diff > max_abs_err) max_abs_err <= diff;
`ifdef AP_SWEEP_SQERR_EN
      sum_sq_err  <= sum_sq_err + QW'(diff_sq);
`endif
    end
  end

endmodule

// File: tb/tb_ap_mult_err_sweep.sv
// Directed bench: two sweepers (latency 0 and 2) driven by bench-side model multipliers.
// Expected metrics are hand-computed for WIDTH=4.
module tb_ap_mult_err_sweep;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  int         prod_mode;
  bit         two_stage;
  int         checks = 0;
  int         errors = 0;

  logic       busy0, done0, busy2, done2;
  logic [3:0] a0, b0, a2, b2;
  logic [7:0] ap0, ap2, p1, p2;
  logic [8:0] err0, err2;
  logic [15:0] sum0, sum2;
  logic [7:0] max0, max2;
`ifdef AP_SWEEP_SQERR_EN
  logic [23:0] sq0, sq2;
`endif

  always #5 clk = ~clk;

  // Model multiplier for the combinational instance
  always_comb begin
    case (prod_mode)
      1:       ap0 = 8'd0;
      2:       ap0 = ({4'd0, a0} * {4'd0, b0}) & 8'hFE;
      default: ap0 = {4'd0, a0} * {4'd0, b0};
    endcase
  end

  // Registered loopback for the latency-2 instance, one or two stages
  always @(posedge clk) begin
    p1 <= {4'd0, a2} * {4'd0, b2};
    p2 <= p1;
  end
  assign ap2 = two_stage ? p2 : p1;

  ap_mult_err_sweep #(.WIDTH(4), .DUT_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy0), .done(done0), .mult_a(a0), .mult_b(b0), .ap_prod(ap0),
    .err_cnt(err0), .sum_abs_err(sum0),
`ifdef AP_SWEEP_SQERR_EN
    .sum_sq_err(sq0),
`endif
    .max_abs_err(max0)
  );

  ap_mult_err_sweep #(.WIDTH(4), .DUT_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy2), .done(done2), .mult_a(a2), .mult_b(b2), .ap_prod(ap2),
    .err_cnt(err2), .sum_abs_err(sum2),
`ifdef AP_SWEEP_SQERR_EN
    .sum_sq_err(sq2),
`endif
    .max_abs_err(max2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a sweep and measures cycles from the start edge to done on both instances
  task automatic applyStimulus(input int mode, input bit pulse_mid);
    int cyc;
    prod_mode = mode;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    checkOutput("done_low_after_start", {63'd0, done0}, 64'd0);
    while (done0 !== 1'b1 && cyc < 600) begin
      @(negedge clk); cyc++;
      start = pulse_mid && (cyc == 40 || cyc == 120);
    end
    start = 1'b0;
    checkOutput("lat0_done_cycle", 64'(cyc), 64'd258);
    while (done2 !== 1'b1 && cyc < 600) begin
      @(negedge clk); cyc++;
    end
    checkOutput("lat2_done_cycle", 64'(cyc), 64'd260);
  endtask

  task automatic checkZeroLat2(input string tag);
    checkOutput({tag, "_lat2_err"}, 64'(err2), 64'd0);
    checkOutput({tag, "_lat2_sum"}, 64'(sum2), 64'd0);
    checkOutput({tag, "_lat2_max"}, 64'(max2), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    prod_mode = 0; two_stage = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {63'd0, busy0}, 64'd0);
    checkOutput("rst_done", {63'd0, done0}, 64'd0);
    checkOutput("rst_mult", 64'({a0, b0}), 64'd0);
    checkOutput("rst_err",  64'(err0), 64'd0);
    checkOutput("rst_sum",  64'(sum0), 64'd0);
    checkOutput("rst_max",  64'(max0), 64'd0);
    rst_n = 1'b1;

    $display("[TB] exact loopback");
    applyStimulus(0, 1'b0);
    checkOutput("exact_err", 64'(err0), 64'd0);
    checkOutput("exact_sum", 64'(sum0), 64'd0);
    checkOutput("exact_max", 64'(max0), 64'd0);
    checkZeroLat2("exact");

    $display("[TB] product tied to zero");
    applyStimulus(1, 1'b0);
    checkOutput("zero_err", 64'(err0), 64'd225);
    checkOutput("zero_sum", 64'(sum0), 64'd14400);
    checkOutput("zero_max", 64'(max0), 64'd225);
`ifdef AP_SWEEP_SQERR_EN
    checkOutput("zero_sq", 64'(sq0), 64'd1537600);
    checkOutput("zero_lat2_sq", 64'(sq2), 64'd0);
`endif
    checkZeroLat2("zero");
    repeat (3) @(negedge clk);
    checkOutput("done_hold", {63'd0, done0}, 64'd1);
    checkOutput("frozen_sum", 64'(sum0), 64'd14400);

    $display("[TB] bit 0 forced low");
    applyStimulus(2, 1'b0);
    checkOutput("bit0_err", 64'(err0), 64'd64);
    checkOutput("bit0_sum", 64'(sum0), 64'd64);
    checkOutput("bit0_max", 64'(max0), 64'd1);

    $display("[TB] latency misalignment");
    two_stage = 1'b0;
    applyStimulus(0, 1'b0);
    checkOutput("misalign_err_nz", {63'd0, (err2 != 9'd0)}, 64'd1);
    two_stage = 1'b1;

    $display("[TB] abort at idx 100 with start");
    prod_mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("abort_idx", 64'({a0, b0}), 64'd100);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checkOutput("abort_busy", {63'd0, busy0}, 64'd0);
    checkOutput("abort_done", {63'd0, done0}, 64'd0);
    checkOutput("abort_err",  64'(err0), 64'd78);
    checkOutput("abort_sum",  64'(sum0), 64'd1836);
    checkOutput("abort_max",  64'(max0), 64'd75);
    repeat (4) @(negedge clk);
    checkOutput("abort_idle_busy", {63'd0, busy0}, 64'd0);
    checkOutput("abort_hold_sum",  64'(sum0), 64'd1836);

    $display("[TB] restart with stray start pulses");
    applyStimulus(1, 1'b1);
    checkOutput("restart_err", 64'(err0), 64'd225);
    checkOutput("restart_sum", 64'(sum0), 64'd14400);
    checkOutput("restart_max", 64'(max0), 64'd225);

    $display("[TB] async reset mid-sweep");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {63'd0, busy0}, 64'd0);
    checkOutput("arst_mult", 64'({a0, b0}), 64'd0);
    checkOutput("arst_err",  64'(err0), 64'd0);
    checkOutput("arst_sum",  64'(sum0), 64'd0);
    checkOutput("arst_max",  64'(max0), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(1, 1'b0);
    checkOutput("post_rst_err", 64'(err0), 64'd225);
    checkOutput("post_rst_sum", 64'(sum0), 64'd14400);
    checkOutput("post_rst_max", 64'(max0), 64'd225);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
